mem_bus_arbiter: RTL

- Shares the single-port unified instruction/data memory bus between two masters.
- Master 0 is the multicycle CPU core (its Adr/WriteData/MemWrite/ReadData interface).
- Master 1 is a secondary requester (DMA or debug loader).
- Round-robin arbitration over a registered request/ready handshake to a memory that acknowledges after a variable number of wait states.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_select.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef logic owner_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_select.sv
// Combinational two-way round-robin pick; the master that did not win last time wins a tie.
module rr_select
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);

    // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        grant_valid = req0 | req1;
        grant_owner = owner_t'(1'b0);
        if (req0 && req1) begin
            grant_owner = ~last_grant;
        end else if (req1) begin
            grant_owner = owner_t'(1'b1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the unified memory bus between the CPU core (master 0) and a secondary requester (master 1).
// Optional wait-state timeout abort is built when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    arb_state_t        state, state_nxt;
    owner_t            owner_q;
    owner_t            last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              grant_valid;
    owner_t            grant_owner;
    logic              timeout_hit;
    logic              err_set;

    rr_select u_rr_select (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Counts ISSUE cycles already spent without an ack; an ack in the limit cycle still wins.
    assign timeout_hit = (state == ISSUE) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign err_set     = timeout_hit;
    assign bus_err     = (state == DONE) && err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != ISSUE) begin
                wait_cnt <= '0;
            end else if (!mem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == IDLE) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign err_set        = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_q    <= owner_t'(1'b0);
            last_grant <= owner_t'(1'b1);
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        we_q    <= grant_owner ? m1_we    : m0_we;
                        adr_q   <= grant_owner ? m1_adr   : m0_adr;
                        wdata_q <= grant_owner ? m1_wdata : m0_wdata;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                    end else if (err_set) begin
                        rdata_q <= DATA_W'(ERR_RDATA);
                    end
                end
                DONE: begin
                    last_grant <= owner_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == ISSUE);
    assign mem_we    = we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign m0_ready  = (state == DONE) && (owner_q == owner_t'(1'b0));
    assign m1_ready  = (state == DONE) && (owner_q == owner_t'(1'b1));

endmodule
